cordic_job_responder: RTL and testbench

Responder end of the level-based `start`/`done` job handshake used to drive the CORDIC calculator. It accepts one job at a time from an initiator (bench sequencer or host FSM), latches the operands and launches an iterative CORDIC core through a single-cycle `core_go`. It captures the core's result, holds `done` until the initiator releases `start`, and reports iteration cycle count and error/timeout status. It sits between any job initiator and the core datapath, decoupling initiator operand changes from core operation.

---
 rtl/cordic_job_responder.sv | 190 +++++++++++++++++++
 tb/tb_cordic_job_responder.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_job_responder.sv
// Responder side of the level start/done job handshake in front of an iterative CORDIC core.
// Latches one job, launches the core, captures its result or a timeout, and holds done until start drops.
module cordic_job_responder #(
    parameter int W       = 64,
    parameter int TMO_PAD = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] A,
    input  logic [W-1:0] Xin,
    input  logic [W-1:0] Yin,
    input  logic [5:0]   dur,
    input  logic [2:0]   mode,
    input  logic         start,
    output logic [W-1:0] X,
    output logic [W-1:0] Y,
    output logic [W-1:0] zcal,
    output logic         done,
    output logic         err,
    output logic [5:0]   cycles,
    output logic [W-1:0] core_a,
    output logic [W-1:0] core_x,
    output logic [W-1:0] core_y,
    output logic [2:0]   core_mode,
    output logic [5:0]   core_dur,
    output logic         core_go,
    output logic         core_abort,
    input  logic [W-1:0] core_rx,
    input  logic [W-1:0] core_ry,
    input  logic [W-1:0] core_rz,
    input  logic         core_valid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t         state_reg, state_next;
    logic [6:0]     cnt_reg, cnt_next;
    logic [W-1:0]   x_reg, x_next, y_reg, y_next, z_reg, z_next;
    logic           err_reg, err_next;
    logic [5:0]     cycles_reg, cycles_next;
    logic [W-1:0]   core_a_reg, core_a_next, core_x_reg, core_x_next, core_y_reg, core_y_next;
    logic [2:0]     core_mode_reg, core_mode_next;
    logic [5:0]     core_dur_reg, core_dur_next;
    logic           core_go_reg, core_go_next;
    logic           core_abort_reg, core_abort_next;

    // The wait counter runs 7 bits wide so dur+TMO_PAD (up to 67) is always reachable;
    // only the reported cycle count saturates at 63.
    logic [6:0]     cnt_inc;
    logic [6:0]     tmo_limit;
    logic [5:0]     cnt_sat;

    assign cnt_inc   = (cnt_reg == 7'h7f) ? cnt_reg : cnt_reg + 7'd1;
    assign tmo_limit = {1'b0, core_dur_reg} + 7'(TMO_PAD);
    assign cnt_sat   = (cnt_inc > 7'd63) ? 6'd63 : cnt_inc[5:0];

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        x_next          = x_reg;
        y_next          = y_reg;
        z_next          = z_reg;
        err_next        = err_reg;
        cycles_next     = cycles_reg;
        core_a_next     = core_a_reg;
        core_x_next     = core_x_reg;
        core_y_next     = core_y_reg;
        core_mode_next  = core_mode_reg;
        core_dur_next   = core_dur_reg;
        core_go_next    = 1'b0;
        core_abort_next = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    core_a_next    = A;
                    core_x_next    = Xin;
                    core_y_next    = Yin;
                    core_mode_next = mode;
                    core_dur_next  = dur;
                    cnt_next       = '0;
                    state_next     = (mode > 3'd5) ? S_CHECK : S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (!start) begin
                    core_abort_next = 1'b1;
                    state_next      = S_IDLE;
                end else begin
                    core_go_next = 1'b1;
                    state_next   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!start) begin
                    core_abort_next = 1'b1;
                    state_next      = S_IDLE;
                end else begin
                    cnt_next = cnt_inc;
                    // A result arriving on the timeout cycle still counts as success.
                    if (core_valid) begin
                        x_next      = core_rx;
                        y_next      = core_ry;
                        z_next      = core_rz;
                        err_next    = 1'b0;
                        cycles_next = cnt_sat;
                        state_next  = S_DONE;
                    end else if (cnt_inc == tmo_limit) begin
                        x_next          = '0;
                        y_next          = '0;
                        z_next          = '0;
                        err_next        = 1'b1;
                        cycles_next     = cnt_sat;
                        core_abort_next = 1'b1;
                        state_next      = S_DONE;
                    end
                end
            end
            S_CHECK: begin
                x_next      = '0;
                y_next      = '0;
                z_next      = '0;
                err_next    = 1'b1;
                cycles_next = '0;
                state_next  = S_DONE;
            end
            S_DONE: begin
                if (!start) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= '0;
            x_reg          <= '0;
            y_reg          <= '0;
            z_reg          <= '0;
            err_reg        <= 1'b0;
            cycles_reg     <= '0;
            core_a_reg     <= '0;
            core_x_reg     <= '0;
            core_y_reg     <= '0;
            core_mode_reg  <= '0;
            core_dur_reg   <= '0;
            core_go_reg    <= 1'b0;
            core_abort_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            x_reg          <= x_next;
            y_reg          <= y_next;
            z_reg          <= z_next;
            err_reg        <= err_next;
            cycles_reg     <= cycles_next;
            core_a_reg     <= core_a_next;
            core_x_reg     <= core_x_next;
            core_y_reg     <= core_y_next;
            core_mode_reg  <= core_mode_next;
            core_dur_reg   <= core_dur_next;
            core_go_reg    <= core_go_next;
            core_abort_reg <= core_abort_next;
        end
    end

    assign X          = x_reg;
    assign Y          = y_reg;
    assign zcal       = z_reg;
    assign err        = err_reg;
    assign cycles     = cycles_reg;
    assign done       = (state_reg == S_DONE);
    assign core_a     = core_a_reg;
    assign core_x     = core_x_reg;
    assign core_y     = core_y_reg;
    assign core_mode  = core_mode_reg;
    assign core_dur   = core_dur_reg;
    assign core_go    = core_go_reg;
    assign core_abort = core_abort_reg;

endmodule

// File: tb/tb_cordic_job_responder.sv
// Randomized bench for cordic_job_responder: a job-level reference model predicts result,
// status, cycle count, pulse counts and latency for every handshake.
module tb_cordic_job_responder;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] A = '0, Xin = '0, Yin = '0;
    logic [5:0]   dur = '0;
    logic [2:0]   mode = '0;
    logic         start = 1'b0;
    logic [W-1:0] X, Y, zcal, core_a, core_x, core_y;
    logic         done, err, core_go, core_abort;
    logic [5:0]   cycles, core_dur;
    logic [2:0]   core_mode;
    logic [W-1:0] core_rx = '0, core_ry = '0, core_rz = '0;
    logic         model_valid = 1'b0, stray_valid = 1'b0;
    logic         core_valid;

    int errors = 0;
    int checks = 0;
    int core_lat = 0;
    int cd = 0;
    logic [W-1:0] last_x = '0, last_y = '0, last_z = '0;
    logic         last_err = 1'b0;
    logic [5:0]   last_cyc = '0;

    assign core_valid = model_valid | stray_valid;

    always #5 clk = ~clk;

    cordic_job_responder #(.W(W), .TMO_PAD(4)) dut (
        .clk(clk), .rst_n(rst_n), .A(A), .Xin(Xin), .Yin(Yin), .dur(dur), .mode(mode),
        .start(start), .X(X), .Y(Y), .zcal(zcal), .done(done), .err(err), .cycles(cycles),
        .core_a(core_a), .core_x(core_x), .core_y(core_y), .core_mode(core_mode),
        .core_dur(core_dur), .core_go(core_go), .core_abort(core_abort),
        .core_rx(core_rx), .core_ry(core_ry), .core_rz(core_rz), .core_valid(core_valid)
    );

    // Core stand-in: answers core_lat cycles after core_go (0 = never), cancelled by abort or reset.
    always @(negedge clk) begin
        model_valid = 1'b0;
        if (!rst_n || core_abort) begin
            cd = 0;
        end else if (core_go) begin
            core_rx = core_x + core_a;
            core_ry = core_y ^ core_a;
            core_rz = core_a + 64'hAB;
            if (core_lat == 1) model_valid = 1'b1;
            else if (core_lat > 1) cd = core_lat - 1;
        end else if (cd > 0) begin
            cd = cd - 1;
            if (cd == 0) model_valid = 1'b1;
        end
    end

    task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [2:0] m, input logic [5:0] d, input int lat, input bit scramble);
        logic [W-1:0] ex, ey, ez;
        logic         eerr;
        logic [5:0]   ecyc;
        int n, tmo, egos, eab, eedges, edges, gos, aborts;
        bit got;
        tmo = int'(d) + 4;
        n = 0;
        if (m > 3'd5) begin
            ex = '0; ey = '0; ez = '0; eerr = 1'b1; egos = 0; eab = 0; eedges = 2;
        end else if (lat != 0 && lat <= tmo) begin
            n = lat; ex = x + a; ey = y ^ a; ez = a + 64'hAB; eerr = 1'b0; egos = 1; eab = 0;
            eedges = n + 2;
        end else begin
            n = tmo; ex = '0; ey = '0; ez = '0; eerr = 1'b1; egos = 1; eab = 1; eedges = n + 2;
        end
        ecyc = (n > 63) ? 6'd63 : 6'(n);

        @(negedge clk);
        A = a; Xin = x; Yin = y; mode = m; dur = d; core_lat = lat; start = 1'b1;
        edges = 0; gos = 0; aborts = 0; got = 1'b0;
        while (!got && edges < 200) begin
            @(negedge clk);
            edges++;
            if (core_go) begin
                gos++;
                checks++;
                if (core_a !== a || core_x !== x || core_y !== y || core_mode !== m || core_dur !== d) begin
                    errors++;
                    $display("FAIL latch: got a=%0h x=%0h y=%0h m=%0d d=%0d expected a=%0h x=%0h y=%0h m=%0d d=%0d",
                             core_a, core_x, core_y, core_mode, core_dur, a, x, y, m, d);
                end
            end
            if (core_abort) aborts++;
            if (core_go && core_abort) begin
                errors++;
                $display("FAIL go_abort_overlap: got both high expected exclusive");
            end
            if (done) got = 1'b1;
            else if (scramble) begin
                A = {$urandom, $urandom}; Xin = {$urandom, $urandom}; Yin = {$urandom, $urandom};
                mode = 3'($urandom); dur = 6'($urandom);
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", edges);
        end
        checks++;
        if (edges !== eedges) begin
            errors++;
            $display("FAIL latency: got %0d edges expected %0d", edges, eedges);
        end
        checks++;
        if (X !== ex || Y !== ey || zcal !== ez) begin
            errors++;
            $display("FAIL result: got X=%0h Y=%0h z=%0h expected X=%0h Y=%0h z=%0h", X, Y, zcal, ex, ey, ez);
        end
        checks++;
        if (err !== eerr || cycles !== ecyc) begin
            errors++;
            $display("FAIL status: got err=%0b cycles=%0d expected err=%0b cycles=%0d", err, cycles, eerr, ecyc);
        end
        checks++;
        if (gos !== egos || aborts !== eab) begin
            errors++;
            $display("FAIL pulses: got go=%0d abort=%0d expected go=%0d abort=%0d", gos, aborts, egos, eab);
        end
        $display("job mode=%0d dur=%0d lat=%0d err=%0b cycles=%0d edges=%0d", m, d, lat, err, cycles, edges);
        last_x = ex; last_y = ey; last_z = ez; last_err = eerr; last_cyc = ecyc;
        A = {$urandom, $urandom}; Xin = {$urandom, $urandom}; mode = 3'($urandom); dur = 6'($urandom);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || core_abort !== 1'b0 || X !== ex || err !== eerr) begin
            errors++;
            $display("FAIL release: got done=%0b abort=%0b X=%0h err=%0b expected done=0 abort=0 X=%0h err=%0b",
                     done, core_abort, X, err, ex, eerr);
        end
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if (done !== 1'b0 || err !== 1'b0 || core_go !== 1'b0 || core_abort !== 1'b0 || cycles !== 6'd0) begin
            errors++;
            $display("FAIL %s_ctrl: got done=%0b err=%0b go=%0b abort=%0b cycles=%0d expected all 0",
                     tag, done, err, core_go, core_abort, cycles);
        end
        checks++;
        if (X !== '0 || Y !== '0 || zcal !== '0 || core_a !== '0 || core_x !== '0 || core_y !== '0
            || core_mode !== 3'd0 || core_dur !== 6'd0) begin
            errors++;
            $display("FAIL %s_data: got X=%0h Y=%0h z=%0h ca=%0h cx=%0h cy=%0h cm=%0d cd=%0d expected all 0",
                     tag, X, Y, zcal, core_a, core_x, core_y, core_mode, core_dur);
        end
    endtask

    task automatic test_reset();
        #3;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("post_reset");
    endtask

    task automatic test_normal();
        run_job(64'h0, 64'h1, 64'h2, 3'b101, 6'd63, 40, 1'b0);
    endtask

    task automatic test_timeout();
        run_job({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 3'd0, 6'd10, 0, 1'b0);
    endtask

    task automatic test_illegal();
        run_job({$urandom, $urandom}, 64'h5, 64'h6, 3'b111, 6'd20, 3, 1'b0);
        run_job({$urandom, $urandom}, 64'h7, 64'h8, 3'b110, 6'd20, 3, 1'b0);
    endtask

    task automatic test_boundaries();
        run_job(64'h10, 64'h20, 64'h30, 3'd2, 6'd10, 14, 1'b0);
        run_job(64'h11, 64'h21, 64'h31, 3'd3, 6'd10, 15, 1'b0);
        run_job(64'h12, 64'h22, 64'h32, 3'd4, 6'd63, 0, 1'b0);
        run_job(64'h13, 64'h23, 64'h33, 3'd1, 6'd63, 65, 1'b0);
        run_job(64'h14, 64'h24, 64'h34, 3'd0, 6'd0, 1, 1'b0);
    endtask

    task automatic test_abort();
        int k;
        run_job(64'h100, 64'h200, 64'h300, 3'd1, 6'd30, 7, 1'b0);
        @(negedge clk);
        A = 64'hDEAD; Xin = 64'hBEEF; Yin = 64'h1234; mode = 3'd2; dur = 6'd63; core_lat = 0; start = 1'b1;
        k = 0;
        while (!core_go && k < 5) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (!core_go) begin
            errors++;
            $display("FAIL abort_go: got no core_go expected one");
        end
        repeat (5) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (core_abort !== 1'b1 || core_go !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_pulse: got abort=%0b go=%0b done=%0b expected abort=1 go=0 done=0",
                     core_abort, core_go, done);
        end
        @(negedge clk);
        checks++;
        if (core_abort !== 1'b0) begin
            errors++;
            $display("FAIL abort_width: got abort=%0b expected 0", core_abort);
        end
        stray_valid = 1'b1;
        @(negedge clk);
        stray_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (done !== 1'b0 || X !== last_x || Y !== last_y || zcal !== last_z || err !== last_err
            || cycles !== last_cyc) begin
            errors++;
            $display("FAIL abort_keep: got done=%0b X=%0h Y=%0h z=%0h err=%0b cyc=%0d expected done=0 X=%0h Y=%0h z=%0h err=%0b cyc=%0d",
                     done, X, Y, zcal, err, cycles, last_x, last_y, last_z, last_err, last_cyc);
        end
        $display("abort job dropped in WAIT, outputs held");
    endtask

    task automatic test_back_to_back();
        logic [2:0] m;
        logic [5:0] d;
        int lat, sel, hi;
        for (int j = 0; j < 900; j++) begin
            sel = $urandom_range(0, 9);
            d = 6'($urandom);
            m = 3'($urandom_range(0, 5));
            if (sel == 0) begin
                m = 3'($urandom_range(6, 7));
                lat = $urandom_range(1, 5);
            end else if (sel == 1) begin
                lat = 0;
            end else if (sel == 2) begin
                lat = int'(d) + 4 + $urandom_range(0, 3);
            end else begin
                hi = (int'(d) + 4 < 30) ? int'(d) + 4 : 30;
                lat = $urandom_range(1, hi);
            end
            run_job({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, m, d, lat, 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_reset_midjob();
        int k;
        @(negedge clk);
        A = 64'h55; Xin = 64'h66; Yin = 64'h77; mode = 3'd3; dur = 6'd40; core_lat = 0; start = 1'b1;
        k = 0;
        while (!core_go && k < 5) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (!core_go) begin
            errors++;
            $display("FAIL rst_go: got no core_go expected one");
        end
        #1 rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (core_abort !== 1'b0) begin
            errors++;
            $display("FAIL rst_abort: got abort=%0b expected 0", core_abort);
        end
        #2 rst_n = 1'b1;
        $display("reset applied mid-job");
        run_job(64'h3, 64'h9, 64'hF, 3'd0, 6'd12, 6, 1'b0);
    endtask

    initial begin
        test_reset();
        test_normal();
        test_timeout();
        test_illegal();
        test_boundaries();
        test_abort();
        test_back_to_back();
        test_reset_midjob();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
